// File: rtl/pc_word_out_arbiter_pkg.sv
// Shared definitions for the PC-word output arbiter: field-width defaults,
// the arbiter state encoding and index-width helpers that stay legal for N=1.
package PCWordPkg;

  localparam int NIN_DEF       = 4;
  localparam int NCODE_DEF     = 8;
  localparam int NDATA_OUT_DEF = 24;

  // Index width that never collapses to zero bits (a single channel still
  // needs a 1-bit owner/pointer register).
  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W_DEF = clog2_safe(NIN_DEF);

  typedef logic [IDX_W_DEF-1:0] idx_def_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/pc_word_out_arbiter_rr_priority_pick.sv
// Round-robin priority picker: returns the first asserted request at or
// after ptr, wrapping from N-1 back to 0. Purely combinational.
module rr_priority_pick
  import PCWordPkg::*;
#(
  parameter int N = NIN_DEF,
  parameter int W = clog2_safe(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan ptr, ptr+1, ... and keep the first hit; idx falls back to ptr.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    idx = ptr;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int cand;
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        idx = W'(cand);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_word_out_arbiter.sv
// Round-robin arbiter for the single serialized PC-word output channel.
// The grant is held on one producer from its first flit until its last flit
// has transferred, so multi-part words never interleave. The datapath is a
// zero-latency mux; only the lock state, owner and round-robin pointer are
// registered.
module pc_word_out_arbiter
  import PCWordPkg::*;
#(
  parameter int Nin       = NIN_DEF,
  parameter int Ncode     = NCODE_DEF,
  parameter int Ndata_out = NDATA_OUT_DEF,
  localparam int IW       = clog2_safe(Nin)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [Nin-1:0]           in_v,
  input  logic [Nin-1:0]           in_last,
  input  logic [Nin*Ncode-1:0]     in_code,
  input  logic [Nin*Ndata_out-1:0] in_payload,
  output logic [Nin-1:0]           in_a,
  output logic                     out_v,
  output logic [Ncode-1:0]         out_code,
  output logic [Ndata_out-1:0]     out_payload,
  input  logic                     out_a,
  output logic [IW-1:0]            grant_owner,
  output logic                     locked
);

  arb_state_t    r_state, w_state_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [IW-1:0] r_ptr,   w_ptr_nxt;

  logic [IW-1:0] w_pick_idx;
  logic          w_pick_any;
  logic [IW-1:0] w_sel;
  logic          w_out_v;

  // Next round-robin start after index i; wraps to 0 (constant 0 when Nin=1).
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    if (int'(i) >= Nin - 1) return '0;
    return i + 1'b1;
  endfunction

  rr_priority_pick #(
    .N (Nin),
    .W (IW)
  ) u_pick (
    .req (in_v),
    .ptr (r_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  // Datapath: select the locked owner when BUSY, otherwise the round-robin
  // pick; the ack goes back only to the selected producer.
  always_comb begin
    w_sel       = (r_state == BUSY) ? r_owner : w_pick_idx;
    w_out_v     = 1'b0;
    if (reset_n) begin
      w_out_v = (r_state == BUSY) ? in_v[r_owner] : w_pick_any;
    end
    out_v       = w_out_v;
    out_code    = in_code[int'(w_sel)*Ncode +: Ncode];
    out_payload = in_payload[int'(w_sel)*Ndata_out +: Ndata_out];
    in_a        = '0;
    in_a[w_sel] = out_a & w_out_v;
    grant_owner = reset_n ? w_sel : '0;
    locked      = (r_state == BUSY);
  end

  // Next-state logic: an unacked offer or a non-final flit locks the grant;
  // a final-flit transfer releases it and advances the pointer past the winner.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_out_v) begin
          if (out_a && in_last[w_sel]) begin
            w_ptr_nxt = wrap_inc(w_sel);
          end else begin
            w_state_nxt = BUSY;
            w_owner_nxt = w_sel;
          end
        end
      end
      BUSY: begin
        if (w_out_v && out_a && in_last[r_owner]) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = wrap_inc(r_owner);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, owner and pointer registers; async reset drops any held lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

endmodule
